// File: rtl/deparser_layer_param_if.sv
// Bus bundle for deparser_layer_param: rule configuration port plus the
// header/metadata beat streams. Each beat carries its tag in the top bits.
interface deparser_layer_param_if #(
  parameter int unsigned HEAD_BYTES = 64,
  parameter int unsigned META_BYTES = 64,
  parameter int unsigned TAG_WIDTH  = 8
);
  logic                                i_rule_wren;
  logic                                i_rule_rden;
  logic [31:0]                         i_rule_addr;
  logic [31:0]                         i_rule_wdata;
  logic                                o_rule_rdata_valid;
  logic [31:0]                         o_rule_rdata;
  logic [HEAD_BYTES*8+TAG_WIDTH-1:0]   i_head;
  logic [HEAD_BYTES*8+TAG_WIDTH-1:0]   o_head;
  logic [META_BYTES*8+TAG_WIDTH-1:0]   i_meta;
  logic [META_BYTES*8+TAG_WIDTH-1:0]   o_meta;

  modport master (
    output i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata, i_head, i_meta,
    input  o_rule_rdata_valid, o_rule_rdata, o_head, o_meta
  );

  modport slave (
    input  i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata, i_head, i_meta,
    output o_rule_rdata_valid, o_rule_rdata, o_head, o_meta
  );
endinterface

// File: rtl/deparser_layer_param.sv
// Deparser layer: matches a header type field against per-layer rules, then
// on a hit copies metadata bytes into the header and shifts both toward
// byte 0. Two-cycle fixed latency, one beat per cycle, no backpressure.
module deparser_layer_param #(
  parameter int unsigned LAYER_ID   = 1,
  parameter int unsigned NUM_RULES  = 8,
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned HEAD_BYTES = 64,
  parameter int unsigned META_BYTES = 64,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  deparser_layer_param_if.slave  bus
);

  localparam int unsigned HW   = HEAD_BYTES * 8;
  localparam int unsigned MW   = META_BYTES * 8;
  localparam int unsigned HTOT = HW + TAG_WIDTH;
  localparam int unsigned MTOT = MW + TAG_WIDTH;
  localparam int unsigned HIW  = (HEAD_BYTES > 1) ? $clog2(HEAD_BYTES) : 1;
  localparam int unsigned MIW  = (META_BYTES > 1) ? $clog2(META_BYTES) : 1;

  // Byte 0 is the leftmost (most significant) element.
  typedef logic [0:HEAD_BYTES-1][7:0] head_bytes_t;
  typedef logic [0:META_BYTES-1][7:0] meta_bytes_t;

  // Rule table
  logic [NUM_RULES-1:0]                     rule_valid_q, rule_valid_d;
  logic [NUM_RULES-1:0][15:0]               type_data_q, type_data_d;
  logic [NUM_RULES-1:0][15:0]               type_mask_q, type_mask_d;
  logic [7:0]                               type_off_q, type_off_d;
  logic [NUM_RULES-1:0][NUM_KEYS-1:0]       key_valid_q, key_valid_d;
  logic [NUM_RULES-1:0][NUM_KEYS-1:0][7:0]  key_hoff_q, key_hoff_d;
  logic [NUM_RULES-1:0][NUM_KEYS-1:0][7:0]  key_moff_q, key_moff_d;
  logic [NUM_RULES-1:0][7:0]                head_shift_q, head_shift_d;
  logic [NUM_RULES-1:0][7:0]                meta_shift_q, meta_shift_d;

  // Config read port
  logic        rdata_valid_q, rdata_valid_d;
  logic [31:0] rdata_q, rdata_d;

  // Pipeline
  logic [HTOT-1:0] s1_head_q, s1_head_d;
  logic [MTOT-1:0] s1_meta_q, s1_meta_d;
  logic            s1_hit_q, s1_hit_d;
  logic [3:0]      s1_rule_q, s1_rule_d;
  logic [HTOT-1:0] out_head_q, out_head_d;
  logic [MTOT-1:0] out_meta_q, out_meta_d;

  // Address decode
  logic [3:0] a_layer;
  logic [2:0] a_func;
  logic [3:0] a_rule;
  logic [3:0] a_key;
  logic       addr_ok;

  assign a_layer = bus.i_rule_addr[15:12];
  assign a_func  = bus.i_rule_addr[10:8];
  assign a_rule  = bus.i_rule_addr[7:4];
  assign a_key   = bus.i_rule_addr[3:0];
  assign addr_ok = (a_layer == 4'(LAYER_ID)) && (a_func <= 3'd5) &&
                   (32'(a_rule) < NUM_RULES) && (32'(a_key) < NUM_KEYS);

  // Rule table write decode
  always_comb begin
    rule_valid_d = rule_valid_q;
    type_data_d  = type_data_q;
    type_mask_d  = type_mask_q;
    type_off_d   = type_off_q;
    key_valid_d  = key_valid_q;
    key_hoff_d   = key_hoff_q;
    key_moff_d   = key_moff_q;
    head_shift_d = head_shift_q;
    meta_shift_d = meta_shift_q;
    if (bus.i_rule_wren && addr_ok) begin
      if (a_func == 3'd2) type_off_d = bus.i_rule_wdata[7:0];
      for (int unsigned r = 0; r < NUM_RULES; r++) begin
        if (a_rule == 4'(r)) begin
          case (a_func)
            3'd0: rule_valid_d[r] = bus.i_rule_wdata[0];
            3'd1: begin
              type_data_d[r] = bus.i_rule_wdata[15:0];
              type_mask_d[r] = bus.i_rule_wdata[31:16];
            end
            3'd3: begin
              for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (a_key == 4'(k)) begin
                  key_valid_d[r][k] = bus.i_rule_wdata[16];
                  key_moff_d[r][k]  = bus.i_rule_wdata[15:8];
                  key_hoff_d[r][k]  = bus.i_rule_wdata[7:0];
                end
              end
            end
            3'd4:    head_shift_d[r] = bus.i_rule_wdata[7:0];
            3'd5:    meta_shift_d[r] = bus.i_rule_wdata[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux samples the table before this cycle's write lands
  always_comb begin
    rdata_valid_d = bus.i_rule_rden;
    rdata_d       = '0;
    if (bus.i_rule_rden && addr_ok) begin
      if (a_func == 3'd2) rdata_d = {24'd0, type_off_q};
      for (int unsigned r = 0; r < NUM_RULES; r++) begin
        if (a_rule == 4'(r)) begin
          case (a_func)
            3'd0: rdata_d = {31'd0, rule_valid_q[r]};
            3'd1: rdata_d = {type_mask_q[r], type_data_q[r]};
            3'd3: begin
              for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (a_key == 4'(k))
                  rdata_d = {15'd0, key_valid_q[r][k], key_moff_q[r][k], key_hoff_q[r][k]};
              end
            end
            3'd4:    rdata_d = {24'd0, head_shift_q[r]};
            3'd5:    rdata_d = {24'd0, meta_shift_q[r]};
            default: ;
          endcase
        end
      end
    end
  end

  // Stage 1 match: lowest valid rule whose masked type field agrees
  head_bytes_t     in_bytes;
  logic [HIW-1:0]  ti0, ti1;
  logic [15:0]     type_in;
  logic            type_ok;
  logic            match;

  always_comb begin
    in_bytes  = bus.i_head[HW-1:0];
    ti0       = HIW'(type_off_q);
    ti1       = ti0 + HIW'(1);
    type_ok   = (32'(type_off_q) + 32'd1) < HEAD_BYTES;
    type_in   = type_ok ? {in_bytes[ti0], in_bytes[ti1]} : 16'd0;
    match     = 1'b0;
    s1_rule_d = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      if (!match && type_ok && rule_valid_q[r] &&
          ((type_in & type_mask_q[r]) == (type_data_q[r] & type_mask_q[r]))) begin
        match     = 1'b1;
        s1_rule_d = 4'(r);
      end
    end
    s1_hit_d  = match && bus.i_head[HTOT-1];
    s1_head_d = bus.i_head;
    s1_meta_d = bus.i_meta;
  end

  // Stage 2: key replacement in ascending slot order, then zero-fill shifts
  logic [NUM_KEYS-1:0]       sel_kv;
  logic [NUM_KEYS-1:0][7:0]  sel_hoff, sel_moff;
  logic [7:0]                sel_hs, sel_ms;
  head_bytes_t               hb;
  meta_bytes_t               mb;
  logic [HW-1:0]             head_rep, head_sh;
  logic [MW-1:0]             meta_rep, meta_sh;
  logic [TAG_WIDTH-1:0]      htag;

  always_comb begin
    sel_kv   = '0;
    sel_hoff = '0;
    sel_moff = '0;
    sel_hs   = '0;
    sel_ms   = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      if (s1_rule_q == 4'(r)) begin
        sel_kv   = key_valid_q[r];
        sel_hoff = key_hoff_q[r];
        sel_moff = key_moff_q[r];
        sel_hs   = head_shift_q[r];
        sel_ms   = meta_shift_q[r];
      end
    end
    hb = s1_head_q[HW-1:0];
    mb = s1_meta_q[MW-1:0];
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (sel_kv[k] && (32'(sel_hoff[k]) < HEAD_BYTES) && (32'(sel_moff[k]) < META_BYTES))
        hb[HIW'(sel_hoff[k])] = mb[MIW'(sel_moff[k])];
    end
    head_rep = hb;
    meta_rep = mb;
    head_sh  = (32'(sel_hs) >= HEAD_BYTES) ? '0 : (head_rep << {sel_hs, 3'b000});
    meta_sh  = (32'(sel_ms) >= META_BYTES) ? '0 : (meta_rep << {sel_ms, 3'b000});
    htag     = s1_head_q[HTOT-1:HW];
    htag[TAG_WIDTH-2] = s1_hit_q;
    if (s1_hit_q) begin
      out_head_d = {htag, head_sh};
      out_meta_d = {s1_meta_q[MTOT-1:MW], meta_sh};
    end else begin
      out_head_d = {htag, s1_head_q[HW-1:0]};
      out_meta_d = s1_meta_q;
    end
  end

  // All state: rule table, read port and both pipeline stages
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_valid_q  <= '0;
      type_data_q   <= '0;
      type_mask_q   <= '0;
      type_off_q    <= '0;
      key_valid_q   <= '0;
      key_hoff_q    <= '0;
      key_moff_q    <= '0;
      head_shift_q  <= '0;
      meta_shift_q  <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      s1_head_q     <= '0;
      s1_meta_q     <= '0;
      s1_hit_q      <= 1'b0;
      s1_rule_q     <= '0;
      out_head_q    <= '0;
      out_meta_q    <= '0;
    end else begin
      rule_valid_q  <= rule_valid_d;
      type_data_q   <= type_data_d;
      type_mask_q   <= type_mask_d;
      type_off_q    <= type_off_d;
      key_valid_q   <= key_valid_d;
      key_hoff_q    <= key_hoff_d;
      key_moff_q    <= key_moff_d;
      head_shift_q  <= head_shift_d;
      meta_shift_q  <= meta_shift_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      s1_head_q     <= s1_head_d;
      s1_meta_q     <= s1_meta_d;
      s1_hit_q      <= s1_hit_d;
      s1_rule_q     <= s1_rule_d;
      out_head_q    <= out_head_d;
      out_meta_q    <= out_meta_d;
    end
  end

  assign bus.o_head             = out_head_q;
  assign bus.o_meta             = out_meta_q;
  assign bus.o_rule_rdata       = rdata_q;
  assign bus.o_rule_rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_deparser_layer_param.sv
// Directed bench for deparser_layer_param with default parameters.
module tb_deparser_layer_param;

  typedef logic [0:63][7:0] bytes_t;
  localparam logic [3:0] L = 4'd1;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  deparser_layer_param_if #(.HEAD_BYTES(64), .META_BYTES(64), .TAG_WIDTH(8)) bus ();

  deparser_layer_param #(
    .LAYER_ID(1), .NUM_RULES(8), .NUM_KEYS(8),
    .HEAD_BYTES(64), .META_BYTES(64), .TAG_WIDTH(8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bytes_t seq(input logic [7:0] start);
    bytes_t r;
    for (int unsigned i = 0; i < 64; i++) r[i] = start + 8'(i);
    return r;
  endfunction

  task automatic cfg_wr(input logic [3:0] layer, input logic [2:0] fn,
                        input logic [3:0] rule, input logic [3:0] key, input logic [31:0] d);
    @(negedge clk);
    bus.i_rule_wren  = 1'b1;
    bus.i_rule_addr  = {16'd0, layer, 1'b0, fn, rule, key};
    bus.i_rule_wdata = d;
    @(negedge clk);
    bus.i_rule_wren  = 1'b0;
    bus.i_rule_addr  = '0;
    bus.i_rule_wdata = '0;
  endtask

  task automatic cfg_rd(input logic [3:0] layer, input logic [2:0] fn,
                        input logic [3:0] rule, input logic [3:0] key,
                        output logic v, output logic [31:0] d);
    @(negedge clk);
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = {16'd0, layer, 1'b0, fn, rule, key};
    @(negedge clk);
    bus.i_rule_rden = 1'b0;
    bus.i_rule_addr = '0;
    v = bus.o_rule_rdata_valid;
    d = bus.o_rule_rdata;
  endtask

  task automatic run_beat(input logic [519:0] h, input logic [519:0] m,
                          output logic [519:0] oh, output logic [519:0] om);
    @(negedge clk);
    bus.i_head = h;
    bus.i_meta = m;
    @(negedge clk);
    bus.i_head = '0;
    bus.i_meta = '0;
    @(negedge clk);
    oh = bus.o_head;
    om = bus.o_meta;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_rule_wren = 1'b0; bus.i_rule_rden = 1'b0;
    bus.i_rule_addr = '0;   bus.i_rule_wdata = '0;
    bus.i_head = '0;        bus.i_meta = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.o_head !== '0 || bus.o_meta !== '0) begin
      miscompares++;
      $display("FAIL reset_data: head=%h meta=%h required 0", bus.o_head, bus.o_meta);
    end
    vectors++;
    if (bus.o_rule_rdata_valid !== 1'b0 || bus.o_rule_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rd: valid=%b rdata=%h required 0/0", bus.o_rule_rdata_valid, bus.o_rule_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_head !== '0) begin
      miscompares++;
      $display("FAIL reset_release_head: got %h required 0", bus.o_head);
    end
  endtask

  task automatic test_passthrough();
    logic [519:0] oh, om;
    bytes_t h, m;
    h = seq(8'h00);
    m = seq(8'h80);
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, h}) begin
      miscompares++; $display("FAIL pass_head: got %h required %h", oh, {8'h80, h});
    end
    vectors++;
    if (om !== {8'h80, m}) begin
      miscompares++; $display("FAIL pass_meta: got %h required %h", om, {8'h80, m});
    end
    run_beat({8'hC0, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, h}) begin
      miscompares++; $display("FAIL pass_hit_cleared: got %h required %h", oh, {8'h80, h});
    end
    run_beat({8'h40, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h00, h}) begin
      miscompares++; $display("FAIL pass_invalid_beat: got %h required %h", oh, {8'h00, h});
    end
  endtask

  task automatic test_rule0();
    logic [519:0] oh, om;
    bytes_t h, m, eh, em;
    cfg_wr(L, 3'd2, 4'd0, 4'd0, 32'd12);
    cfg_wr(L, 3'd1, 4'd0, 4'd0, 32'hffff_0800);
    cfg_wr(L, 3'd3, 4'd0, 4'd0, 32'h0001_0006);
    cfg_wr(L, 3'd4, 4'd0, 4'd0, 32'd14);
    cfg_wr(L, 3'd5, 4'd0, 4'd0, 32'd1);
    cfg_wr(L, 3'd0, 4'd0, 4'd0, 32'd1);
    h = seq(8'h00); h[12] = 8'h08; h[13] = 8'h00;
    m = seq(8'h10); m[0] = 8'h11;
    for (int unsigned j = 0; j < 64; j++) begin
      eh[j] = (j < 50) ? 8'(j + 14) : 8'h00;
      em[j] = (j < 63) ? 8'(8'h11 + j) : 8'h00;
    end
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, eh}) begin
      miscompares++; $display("FAIL rule0_head: got %h required %h", oh, {8'hC0, eh});
    end
    vectors++;
    if (om !== {8'h80, em}) begin
      miscompares++; $display("FAIL rule0_meta: got %h required %h", om, {8'h80, em});
    end
  endtask

  task automatic test_priority();
    logic [519:0] oh, om;
    bytes_t h, h2, m, e;
    cfg_wr(L, 3'd0, 4'd0, 4'd0, 32'd0);
    cfg_wr(L, 3'd1, 4'd2, 4'd0, 32'hffff_0800);
    cfg_wr(L, 3'd4, 4'd2, 4'd0, 32'd1);
    cfg_wr(L, 3'd0, 4'd2, 4'd0, 32'd1);
    cfg_wr(L, 3'd1, 4'd5, 4'd0, 32'hff00_0800);
    cfg_wr(L, 3'd4, 4'd5, 4'd0, 32'd2);
    cfg_wr(L, 3'd0, 4'd5, 4'd0, 32'd1);
    h = seq(8'h00); h[12] = 8'h08; h[13] = 8'h00;
    m = seq(8'h80);
    for (int unsigned j = 0; j < 64; j++) e[j] = (j < 63) ? h[j+1] : 8'h00;
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, e} || om !== {8'h80, m}) begin
      miscompares++; $display("FAIL prio_rule2: got %h required %h", oh, {8'hC0, e});
    end
    h2 = h; h2[13] = 8'h55;
    for (int unsigned j = 0; j < 64; j++) e[j] = (j < 62) ? h2[j+2] : 8'h00;
    run_beat({8'h80, h2}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, e}) begin
      miscompares++; $display("FAIL prio_mask_rule5: got %h required %h", oh, {8'hC0, e});
    end
    cfg_wr(L, 3'd0, 4'd2, 4'd0, 32'd0);
    for (int unsigned j = 0; j < 64; j++) e[j] = (j < 62) ? h[j+2] : 8'h00;
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, e}) begin
      miscompares++; $display("FAIL prio_after_clear: got %h required %h", oh, {8'hC0, e});
    end
  endtask

  task automatic test_keys();
    logic [519:0] oh, om;
    bytes_t h, h3, h4, m, e, em;
    cfg_wr(L, 3'd1, 4'd3, 4'd0, 32'hffff_1234);
    cfg_wr(L, 3'd3, 4'd3, 4'd0, 32'h0001_0a04);
    cfg_wr(L, 3'd3, 4'd3, 4'd1, 32'h0001_00c8);
    cfg_wr(L, 3'd3, 4'd3, 4'd2, 32'h0001_4609);
    cfg_wr(L, 3'd3, 4'd3, 4'd3, 32'h0001_1404);
    cfg_wr(4'd2, 3'd0, 4'd3, 4'd0, 32'd1);
    h = seq(8'h00); h[12] = 8'h12; h[13] = 8'h34;
    m = seq(8'h40);
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, h}) begin
      miscompares++; $display("FAIL wrong_layer_ignored: got %h required %h", oh, {8'h80, h});
    end
    cfg_wr(L, 3'd0, 4'd3, 4'd0, 32'd1);
    e = h; e[4] = 8'h54;
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, e} || om !== {8'h80, m}) begin
      miscompares++; $display("FAIL keys_replace: got %h required %h", oh, {8'hC0, e});
    end
    h3 = h; h3[13] = 8'h35;
    run_beat({8'h80, h3}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, h3}) begin
      miscompares++; $display("FAIL keys_mask_miss: got %h required %h", oh, {8'h80, h3});
    end
    cfg_wr(L, 3'd4, 4'd3, 4'd0, 32'd64);
    cfg_wr(L, 3'd5, 4'd3, 4'd0, 32'd63);
    em = '0; em[0] = 8'h7f;
    run_beat({8'h80, h}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, 512'd0} || om !== {8'h80, em}) begin
      miscompares++; $display("FAIL shift_limits: head %h meta %h required meta %h", oh, om, {8'h80, em});
    end
    cfg_wr(L, 3'd2, 4'd0, 4'd0, 32'd63);
    h4 = seq(8'h00); h4[63] = 8'h12; h4[0] = 8'h34;
    run_beat({8'h80, h4}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, h4}) begin
      miscompares++; $display("FAIL typeoff_63_miss: got %h required %h", oh, {8'h80, h4});
    end
    cfg_wr(L, 3'd2, 4'd0, 4'd0, 32'd62);
    h4 = seq(8'h00); h4[62] = 8'h12; h4[63] = 8'h34;
    run_beat({8'h80, h4}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'hC0, 512'd0}) begin
      miscompares++; $display("FAIL typeoff_62_hit: got %h required %h", oh, {8'hC0, 512'd0});
    end
  endtask

  task automatic test_config_read();
    logic v;
    logic [31:0] d;
    cfg_rd(L, 3'd3, 4'd3, 4'd3, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'h0001_1404) begin
      miscompares++; $display("FAIL rd_key: valid=%b rdata=%h required 1/00011404", v, d);
    end
    cfg_rd(L, 3'd1, 4'd0, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'hffff_0800) begin
      miscompares++; $display("FAIL rd_type: valid=%b rdata=%h required 1/ffff0800", v, d);
    end
    cfg_rd(L, 3'd2, 4'd0, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'h0000_003e) begin
      miscompares++; $display("FAIL rd_typeoff: valid=%b rdata=%h required 1/0000003e", v, d);
    end
    cfg_rd(L, 3'd0, 4'd15, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'd0) begin
      miscompares++; $display("FAIL rd_rule15: valid=%b rdata=%h required 1/0", v, d);
    end
    cfg_rd(4'd0, 3'd1, 4'd0, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'd0) begin
      miscompares++; $display("FAIL rd_wrong_layer: valid=%b rdata=%h required 1/0", v, d);
    end
    @(negedge clk);
    bus.i_rule_wren  = 1'b1;
    bus.i_rule_rden  = 1'b1;
    bus.i_rule_addr  = {16'd0, L, 1'b0, 3'd5, 4'd1, 4'd0};
    bus.i_rule_wdata = 32'd9;
    @(negedge clk);
    bus.i_rule_wren  = 1'b0;
    bus.i_rule_rden  = 1'b0;
    bus.i_rule_addr  = '0;
    bus.i_rule_wdata = '0;
    vectors++;
    if (bus.o_rule_rdata_valid !== 1'b1 || bus.o_rule_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rd_same_cycle: valid=%b rdata=%h required 1/0", bus.o_rule_rdata_valid, bus.o_rule_rdata);
    end
    cfg_rd(L, 3'd5, 4'd1, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'h9) begin
      miscompares++; $display("FAIL rd_after_write: valid=%b rdata=%h required 1/9", v, d);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_rule_rdata_valid !== 1'b0) begin
      miscompares++; $display("FAIL rd_valid_one_cycle: valid=%b required 0", bus.o_rule_rdata_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [519:0] hin [3];
    logic [519:0] min [3];
    logic [519:0] hexp [3];
    logic [519:0] mexp [3];
    bytes_t a, c, m, em;
    a = seq(8'h00);
    c = seq(8'h00); c[62] = 8'h12; c[63] = 8'h34;
    m = seq(8'h40);
    em = '0; em[0] = 8'h7f;
    hin[0] = {8'h80, a}; min[0] = {8'h80, m}; hexp[0] = {8'h80, a};       mexp[0] = {8'h80, m};
    hin[1] = {8'h40, c}; min[1] = {8'h80, m}; hexp[1] = {8'h00, c};       mexp[1] = {8'h80, m};
    hin[2] = {8'h80, c}; min[2] = {8'h80, m}; hexp[2] = {8'hC0, 512'd0};  mexp[2] = {8'h80, em};
    for (int unsigned cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        vectors++;
        if (bus.o_head !== hexp[cyc-2] || bus.o_meta !== mexp[cyc-2]) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: head %h required %h", cyc - 2, bus.o_head, hexp[cyc-2]);
        end
      end
      if (cyc < 3) begin
        bus.i_head = hin[cyc];
        bus.i_meta = min[cyc];
      end else begin
        bus.i_head = '0;
        bus.i_meta = '0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [519:0] oh, om;
    logic v;
    logic [31:0] d;
    bytes_t c, m;
    c = seq(8'h00); c[62] = 8'h12; c[63] = 8'h34;
    m = seq(8'h40);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_head = {8'h80, c};
      bus.i_meta = {8'h80, m};
    end
    #2;
    rst_n = 1'b0;
    bus.i_head = '0;
    bus.i_meta = '0;
    #1;
    vectors++;
    if (bus.o_head !== '0 || bus.o_meta !== '0) begin
      miscompares++; $display("FAIL reset_async: head %h meta %h required 0", bus.o_head, bus.o_meta);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.o_head !== '0 || bus.o_meta !== '0) begin
        miscompares++; $display("FAIL reset_no_stale%0d: head %h required 0", i, bus.o_head);
      end
    end
    cfg_rd(L, 3'd0, 4'd3, 4'd0, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 32'd0) begin
      miscompares++; $display("FAIL reset_rule_cleared: valid=%b rdata=%h required 1/0", v, d);
    end
    run_beat({8'h80, c}, {8'h80, m}, oh, om);
    vectors++;
    if (oh !== {8'h80, c} || om !== {8'h80, m}) begin
      miscompares++; $display("FAIL reset_first_beat: got %h required %h", oh, {8'h80, c});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_passthrough();
    test_rule0();
    test_priority();
    test_keys();
    test_config_read();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deparser_layer_param.md
DEPARSER_LAYER_PARAM -- requirements
Module: deparser_layer_param

Interface
REQ-001 Parameter LAYER_ID, default 1: layer selected when i_rule_addr[15:12]==LAYER_ID.
REQ-002 Parameter NUM_RULES, default 8: type rules per layer, 1..16.
REQ-003 Parameter NUM_KEYS, default 8: key-replace slots per rule, 1..16.
REQ-004 Parameter HEAD_BYTES, default 64, and META_BYTES, default 64: header and metadata width in bytes; byte 0 is the MSB.
REQ-005 Parameter TAG_WIDTH, default 8: tag field above data; bit TAG_WIDTH-1 is valid, bit TAG_WIDTH-2 is hit.
REQ-006 i_clk  in  1  single clock; all logic on rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_rule_wren  in  1  config write strobe.
REQ-009 i_rule_rden  in  1  config read strobe.
REQ-010 i_rule_addr  in  32  [15:12] layer, [10:8] function, [7:4] rule index, [3:0] key index.
REQ-011 i_rule_wdata  in  32  config write data.
REQ-012 o_rule_rdata_valid  out  1  read data valid.
REQ-013 o_rule_rdata  out  32  read data.
REQ-014 i_head / o_head  in/out  HEAD_BYTES*8+TAG_WIDTH  header beat with tag in the top bits.
REQ-015 i_meta / o_meta  in/out  META_BYTES*8+TAG_WIDTH  metadata beat with tag in the top bits.

Function
REQ-016 Config functions: 0 wdata[0]=rule valid; 1 wdata[15:0]=type data, [31:16]=type mask; 2 wdata[7:0]=layer type offset (byte), shared by all rules; 3 wdata[16]=key valid, [15:8]=meta replace offset, [7:0]=head key offset; 4 wdata[7:0]=rule headShift; 5 wdata[7:0]=rule metaShift; 6-7 reserved.
REQ-017 Writes with wrong layer, reserved function, rule>=NUM_RULES or key>=NUM_KEYS are ignored.
REQ-018 A read returns the stored field zero-extended in the same bit positions, with o_rule_rdata_valid high exactly one cycle after i_rule_rden; an invalid or non-matching address returns 0 and still asserts valid.
REQ-019 A read and a write to the same field in the same cycle return the pre-write value.
REQ-020 A rule write takes effect for head beats sampled in stage 1 on the cycle after the write.
REQ-021 Stage 1 registers the head, the meta, and the index of the matching rule.
REQ-022 Match condition: rule valid, and ({head[typeOff], head[typeOff+1]} & mask) == (data & mask).
REQ-023 The lowest matching rule index wins.
REQ-024 A typeOff+1 >= HEAD_BYTES forces a miss.
REQ-025 Stage 2, on a hit: for each valid key k, head byte keyOffset[k] is replaced by meta byte replaceOffset[k].
REQ-026 Replacement slots are applied in ascending k, so a higher k wins when two slots target the same head byte.
REQ-027 Any key whose offset is >= HEAD_BYTES, or whose replace offset is >= META_BYTES, is skipped.
REQ-028 After replacement, the head is shifted toward byte 0 by headShift bytes and the meta by metaShift bytes.
REQ-029 Shifts are zero-filled, and a shift >= the width yields all-zero data.
REQ-030 On a miss, data passes through unmodified.
REQ-031 Output tags equal input tags, except that o_head hit bit = match result; a beat with head valid=0 is forced to hit=0 and unmodified data.
REQ-032 Latency is fixed at 2 cycles, with one beat accepted per cycle and no backpressure.

Reset
REQ-033 Reset asynchronously clears all pipeline registers and outputs (o_head, o_meta, o_rule_rdata, o_rule_rdata_valid) to 0.
REQ-034 Reset clears all rule valids, key valids, offsets and shifts to 0.
REQ-035 A beat in flight during reset is discarded; no output valid appears until 2 cycles after the first valid input following release.

Verification
REQ-036 Reset, then drive valid beats with no rules configured -> o_head equals i_head 2 cycles later with hit=0 and data unchanged.
REQ-037 Rule 0: type offset 12, data 16'h0800, mask 16'hffff, key0 head 6 <- meta 0, headShift 14, metaShift 1, valid; head bytes 12-13 = 08 00, meta byte 0 = 8'h11 -> output hit=1, original byte 6 now at byte 0 position minus shift, i.e. head byte 6 becomes 8'h11 before the 14-byte shift; meta shifted by 1 byte.
REQ-038 Rules 2 and 5 both match -> rule 2 fields are applied; clear rule 2 valid -> the next beat uses rule 5.
REQ-039 Keys 0 and 3 both target head byte 4 with different meta sources -> the key 3 source byte appears; a key offset of 200 with HEAD_BYTES=64 -> that slot has no effect.
REQ-040 Write rule 1 metaShift=9 and read it in the same cycle -> rdata=0; read next cycle -> rdata=32'h9, valid one cycle after rden; read of rule 15 with NUM_RULES=8 -> rdata=0, valid=1.
REQ-041 Assert i_rst_n low mid-stream while two beats are in flight -> outputs 0 immediately, and no stale beat appears after release.
